// File: rtl/gb_cart_bus_pkg.sv
// Shared types and constants for the cartridge bus sequencer.
//   state_t      : access phase of the bus FSM
//   req_id_t     : which requester owns the access in flight
//   CRAM_WINDOW  : a[15:13] pattern that selects cartridge RAM (/CS low)
//   DEF_*_CYCLES : default phase lengths in clk_sys cycles
package gb_cart_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   typedef enum logic {
      REQ_CPU,
      REQ_DMA
   } req_id_t;

   localparam logic [2:0] CRAM_WINDOW = 3'b101;

   localparam int unsigned DEF_SETUP_CYCLES  = 2;
   localparam int unsigned DEF_STROBE_CYCLES = 8;
   localparam int unsigned DEF_HOLD_CYCLES   = 2;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/gb_cart_bus_if.sv
// Bundle of requester and cartridge pin signals around the bus sequencer.
//   cpu_*  : CPU request pulse, address/data in, read data/done/overrun out
//   dma_*  : DMA level request, address/data in, read data/ack out
//   bus_*  : cartridge address/data pins, direction, /RD, /WR, /CS, PHI
//   busy   : access in flight or CPU request pending
// Modports: slave = sequencer side, master = requester/cartridge side.
interface gb_cart_bus_if;

   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_done;
   logic        cpu_overrun;

   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_wr;
   logic [7:0]  dma_wdata;
   logic [7:0]  dma_rdata;
   logic        dma_ack;

   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din;
   logic        bus_dir;
   logic        bus_nrd;
   logic        bus_nwr;
   logic        bus_ncs;
   logic        bus_clk;
   logic        busy;

   modport slave (
      input  cpu_req, cpu_addr, cpu_wr, cpu_wdata,
      input  dma_req, dma_addr, dma_wr, dma_wdata,
      input  bus_din,
      output cpu_rdata, cpu_done, cpu_overrun,
      output dma_rdata, dma_ack,
      output bus_addr, bus_dout, bus_dir, bus_nrd, bus_nwr, bus_ncs, bus_clk, busy
   );

   modport master (
      output cpu_req, cpu_addr, cpu_wr, cpu_wdata,
      output dma_req, dma_addr, dma_wr, dma_wdata,
      output bus_din,
      input  cpu_rdata, cpu_done, cpu_overrun,
      input  dma_rdata, dma_ack,
      input  bus_addr, bus_dout, bus_dir, bus_nrd, bus_nwr, bus_ncs, bus_clk, busy
   );

endinterface

// File: rtl/gb_cart_bus_phase_timer.sv
// Down-counter timing one bus phase; expires at terminal count zero.
//   clk_sys  in  system clock
//   reset    in  synchronous clear (active high)
//   load     in  load load_val (phase length minus one) on phase entry
//   load_val in  WIDTH-bit reload value
//   count    in  decrement enable; holds at zero, never wraps
//   expired  out counter at zero: current cycle is the last of the phase
module gb_cart_bus_phase_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             count,
   output logic             expired
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/gb_cart_bus_sequencer.sv
// Owns the cartridge bus: arbitrates CPU and DMA requesters and runs each
// access as SETUP -> STROBE -> HOLD with programmable phase lengths.
//   clk_sys  in  system clock
//   reset    in  synchronous active-high reset
//   enable   in  mapper selected; low behaves as reset
//   cart     slave modport of gb_cart_bus_if (requesters + cartridge pins)
//
//   state  | meaning
//   IDLE   | bus parked, addr/data keep last values; arbitration happens here
//   SETUP  | address (and write data) driven, strobes high, PHI low
//   STROBE | PHI high, /RD or /WR low, /CS low in the CRAM window
//   HOLD   | strobes released, addr/data/dir held; done/ack on last cycle
module gb_cart_bus_sequencer
   import gb_cart_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input logic          clk_sys,
   input logic          reset,
   input logic          enable,
   gb_cart_bus_if.slave cart
);

   localparam int unsigned CNT_W =
      $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

   logic clr;
   assign clr = reset | ~enable;

   state_t           state, state_next;
   logic             grant;
   req_id_t          grant_id;
   logic [15:0]      sel_addr;
   logic             sel_wr;
   logic [7:0]       sel_wdata;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_count;
   logic             tmr_expired;
   logic             strobe_last;
   logic             hold_last;

   logic             pend_q;
   logic [15:0]      pend_addr_q;
   logic             pend_wr_q;
   logic [7:0]       pend_wdata_q;
   logic             overrun_q;
   logic             cpu_direct;
   logic             cpu_defer;

   req_id_t          owner_q;
   logic             acc_wr_q;
   logic [15:0]      bus_addr_q;
   logic [7:0]       bus_dout_q;
   logic             bus_dir_q;
   logic             bus_nrd_q;
   logic             bus_nwr_q;
   logic             bus_ncs_q;
   logic             bus_clk_q;
   logic [7:0]       cpu_rdata_q;
   logic [7:0]       dma_rdata_q;

   gb_cart_bus_phase_timer #(.WIDTH(CNT_W)) u_phase_timer (
      .clk_sys  (clk_sys),
      .reset    (clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk_sys) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      grant_id    = REQ_CPU;
      sel_addr    = pend_addr_q;
      sel_wr      = pend_wr_q;
      sel_wdata   = pend_wdata_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      tmr_count   = 1'b0;
      strobe_last = 1'b0;
      hold_last   = 1'b0;
      case (state)
         IDLE: begin
            if (pend_q) begin
               grant = 1'b1;
            end else if (cart.cpu_req) begin
               grant     = 1'b1;
               sel_addr  = cart.cpu_addr;
               sel_wr    = cart.cpu_wr;
               sel_wdata = cart.cpu_wdata;
            end else if (cart.dma_req) begin
               grant     = 1'b1;
               grant_id  = REQ_DMA;
               sel_addr  = cart.dma_addr;
               sel_wr    = cart.dma_wr;
               sel_wdata = cart.dma_wdata;
            end
            if (grant) begin
               state_next = SETUP;
               tmr_load   = 1'b1;
               tmr_val    = SETUP_LD;
            end
         end
         SETUP: begin
            if (tmr_expired) begin
               state_next = STROBE;
               tmr_load   = 1'b1;
               tmr_val    = STROBE_LD;
            end else begin
               tmr_count = 1'b1;
            end
         end
         STROBE: begin
            if (tmr_expired) begin
               state_next  = HOLD;
               tmr_load    = 1'b1;
               tmr_val     = HOLD_LD;
               strobe_last = 1'b1;
            end else begin
               tmr_count = 1'b1;
            end
         end
         HOLD: begin
            if (tmr_expired) begin
               state_next = IDLE;
               hold_last  = 1'b1;
            end else begin
               tmr_count = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A CPU request not granted straight away goes to the one-deep pending slot.
   // In IDLE the pending entry is handed to the bus this cycle, so the slot is
   // free again for a request arriving in that same cycle.
   assign cpu_direct = (state == IDLE) && !pend_q && cart.cpu_req;
   assign cpu_defer  = cart.cpu_req && !cpu_direct;

   always_ff @(posedge clk_sys) begin
      if (clr) begin
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
         pend_wr_q    <= 1'b0;
         pend_wdata_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         if (pend_q && (state == IDLE)) begin
            pend_q <= 1'b0;
         end
         if (cpu_defer) begin
            if (pend_q && (state != IDLE)) begin
               overrun_q <= 1'b1;
            end else begin
               pend_q       <= 1'b1;
               pend_addr_q  <= cart.cpu_addr;
               pend_wr_q    <= cart.cpu_wr;
               pend_wdata_q <= cart.cpu_wdata;
            end
         end
      end
   end

   // Pin registers are computed from the next state so they line up with the
   // state register and come out glitch-free.
   always_ff @(posedge clk_sys) begin
      if (clr) begin
         owner_q     <= REQ_CPU;
         acc_wr_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_dout_q  <= '0;
         bus_dir_q   <= 1'b0;
         bus_nrd_q   <= 1'b1;
         bus_nwr_q   <= 1'b1;
         bus_ncs_q   <= 1'b1;
         bus_clk_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (grant) begin
            owner_q    <= grant_id;
            acc_wr_q   <= sel_wr;
            bus_addr_q <= sel_addr;
            if (sel_wr) begin
               bus_dout_q <= sel_wdata;
            end
         end
         if (strobe_last && !acc_wr_q) begin
            if (owner_q == REQ_CPU) begin
               cpu_rdata_q <= cart.bus_din;
            end else begin
               dma_rdata_q <= cart.bus_din;
            end
         end
         bus_clk_q <= (state_next == STROBE);
         bus_nrd_q <= !((state_next == STROBE) && !acc_wr_q);
         bus_nwr_q <= !((state_next == STROBE) && acc_wr_q);
         bus_ncs_q <= !((state_next == STROBE) && (bus_addr_q[15:13] == CRAM_WINDOW));
         bus_dir_q <= (state_next != IDLE) && (grant ? sel_wr : acc_wr_q);
      end
   end

   assign cart.cpu_done    = hold_last && (owner_q == REQ_CPU) && !clr;
   assign cart.dma_ack     = hold_last && (owner_q == REQ_DMA) && !clr;
   assign cart.cpu_rdata   = cpu_rdata_q;
   assign cart.dma_rdata   = dma_rdata_q;
   assign cart.cpu_overrun = overrun_q;
   assign cart.bus_addr    = bus_addr_q;
   assign cart.bus_dout    = bus_dout_q;
   assign cart.bus_dir     = bus_dir_q;
   assign cart.bus_nrd     = bus_nrd_q;
   assign cart.bus_nwr     = bus_nwr_q;
   assign cart.bus_ncs     = bus_ncs_q;
   assign cart.bus_clk     = bus_clk_q;
   assign cart.busy        = (state != IDLE) || pend_q;

endmodule

// File: tb/tb_gb_cart_bus_sequencer.sv
// Directed bench for gb_cart_bus_sequencer: default 2/8/2 instance plus a
// 1/1/1 instance for the short-phase and back-to-back cases.
module tb_gb_cart_bus_sequencer;
   import gb_cart_bus_pkg::*;

   logic clk_sys = 1'b0;
   logic reset;
   logic enable;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_sys = ~clk_sys;

   gb_cart_bus_if cb ();
   gb_cart_bus_if cf ();

   gb_cart_bus_sequencer dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .enable  (enable),
      .cart    (cb.slave)
   );

   gb_cart_bus_sequencer #(
      .SETUP_CYCLES  (1),
      .STROBE_CYCLES (1),
      .HOLD_CYCLES   (1)
   ) dut_fast (
      .clk_sys (clk_sys),
      .reset   (reset),
      .enable  (enable),
      .cart    (cf.slave)
   );

   // Cartridge model: fixed byte at 0x4123, otherwise a hash of the address.
   function automatic logic [7:0] cart_data(input logic [15:0] a);
      if (a == 16'h4123) return 8'h5A;
      return a[15:8] ^ a[7:0] ^ 8'hC3;
   endfunction

   assign cb.bus_din = cart_data(cb.bus_addr);
   assign cf.bus_din = cart_data(cf.bus_addr);

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({cb.bus_nrd, cb.bus_nwr, cb.bus_ncs, cb.bus_dir, cb.bus_clk} !== 5'b11100) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 11100",
                  {cb.bus_nrd, cb.bus_nwr, cb.bus_ncs, cb.bus_dir, cb.bus_clk});
      end
      checks++;
      if ({cb.bus_addr, cb.bus_dout, cb.cpu_rdata, cb.dma_rdata} !== 40'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0",
                  {cb.bus_addr, cb.bus_dout, cb.cpu_rdata, cb.dma_rdata});
      end
      checks++;
      if ({cb.cpu_done, cb.dma_ack, cb.busy, cb.cpu_overrun, cf.busy} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {cb.cpu_done, cb.dma_ack, cb.busy, cb.cpu_overrun, cf.busy});
      end
      reset = 1'b0;
      enable = 1'b0;
      cb.cpu_req = 1'b1;
      cb.cpu_addr = 16'h4000;
      @(negedge clk_sys);
      cb.cpu_req = 1'b0;
      repeat (2) @(negedge clk_sys);
      checks++;
      if ({cb.busy, cb.bus_nrd, cb.bus_addr} !== {1'b0, 1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL enable_low_ignores_req: got busy=%b nrd=%b addr=%h expected 0 1 0000",
                  cb.busy, cb.bus_nrd, cb.bus_addr);
      end
      enable = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic test_cpu_read();
      int nrd_low = 0, nrd_first = -1, clk_hi = 0, ncs_low = 0, nwr_low = 0;
      int done_at = -1, done_cnt = 0;
      logic [7:0] rd = 8'h00;
      logic [15:0] addr1 = 16'h0;
      cb.cpu_req = 1'b1;
      cb.cpu_addr = 16'h4123;
      cb.cpu_wr = 1'b0;
      cb.cpu_wdata = 8'hFF;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk_sys);
         if (k == 1) addr1 = cb.bus_addr;
         if (!cb.bus_nrd) begin
            nrd_low++;
            if (nrd_first < 0) nrd_first = k;
         end
         if (cb.bus_clk) clk_hi++;
         if (!cb.bus_ncs) ncs_low++;
         if (!cb.bus_nwr) nwr_low++;
         if (cb.cpu_done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               rd = cb.cpu_rdata;
            end
         end
         cb.cpu_req = 1'b0;
      end
      checks++;
      if (addr1 !== 16'h4123) begin
         errors++;
         $display("FAIL read_setup_addr: got %h expected 4123", addr1);
      end
      checks++;
      if (nrd_low != 8 || nrd_first != 3) begin
         errors++;
         $display("FAIL read_nrd_window: got %0d cycles from %0d expected 8 from 3", nrd_low, nrd_first);
      end
      checks++;
      if (clk_hi != 8 || ncs_low != 0 || nwr_low != 0) begin
         errors++;
         $display("FAIL read_clk_ncs_nwr: got clk_hi=%0d ncs_low=%0d nwr_low=%0d expected 8 0 0",
                  clk_hi, ncs_low, nwr_low);
      end
      checks++;
      if (done_at != 12 || done_cnt != 1) begin
         errors++;
         $display("FAIL read_done_latency: got at %0d count %0d expected at 12 count 1", done_at, done_cnt);
      end
      checks++;
      if (rd !== 8'h5A) begin
         errors++;
         $display("FAIL read_rdata: got %h expected 5a", rd);
      end
   endtask

   task automatic test_cpu_write();
      int both_low = 0, ncs_low = 0, dir_hi = 0, nrd_low = 0, done_at = -1;
      logic [7:0] dout1 = 8'h00;
      logic dir13 = 1'b1;
      cb.cpu_req = 1'b1;
      cb.cpu_addr = 16'hA010;
      cb.cpu_wr = 1'b1;
      cb.cpu_wdata = 8'h3C;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk_sys);
         if (k == 1) dout1 = cb.bus_dout;
         if (k == 13) dir13 = cb.bus_dir;
         if (!cb.bus_ncs && !cb.bus_nwr) both_low++;
         if (!cb.bus_ncs) ncs_low++;
         if (!cb.bus_nrd) nrd_low++;
         if (cb.bus_dir) dir_hi++;
         if (cb.cpu_done && done_at < 0) done_at = k;
         cb.cpu_req = 1'b0;
      end
      checks++;
      if (both_low != 8 || ncs_low != 8 || nrd_low != 0) begin
         errors++;
         $display("FAIL write_ncs_nwr: got both=%0d ncs=%0d nrd=%0d expected 8 8 0", both_low, ncs_low, nrd_low);
      end
      checks++;
      if (dir_hi != 12 || dir13 !== 1'b0) begin
         errors++;
         $display("FAIL write_dir: got %0d cycles, after=%b expected 12 cycles, after=0", dir_hi, dir13);
      end
      checks++;
      if (dout1 !== 8'h3C || done_at != 12) begin
         errors++;
         $display("FAIL write_dout_done: got dout=%h done_at=%0d expected 3c 12", dout1, done_at);
      end
   endtask

   task automatic test_priority();
      int done_at = -1, ack_at = -1, ack_cnt = 0;
      logic [15:0] addr1 = 16'h0, addr14 = 16'h0;
      logic [7:0] crd = 8'h00, drd = 8'h00;
      cb.cpu_req = 1'b1;
      cb.cpu_addr = 16'h4000;
      cb.cpu_wr = 1'b0;
      cb.dma_req = 1'b1;
      cb.dma_addr = 16'hA000;
      cb.dma_wr = 1'b0;
      cb.dma_wdata = 8'h11;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         if (k == 1) addr1 = cb.bus_addr;
         if (k == 14) addr14 = cb.bus_addr;
         if (cb.cpu_done && done_at < 0) begin
            done_at = k;
            crd = cb.cpu_rdata;
         end
         if (cb.dma_ack) begin
            ack_cnt++;
            if (ack_at < 0) begin
               ack_at = k;
               drd = cb.dma_rdata;
            end
            cb.dma_req = 1'b0;
         end
         cb.cpu_req = 1'b0;
      end
      cb.dma_req = 1'b0;
      checks++;
      if (addr1 !== 16'h4000 || addr14 !== 16'hA000) begin
         errors++;
         $display("FAIL prio_order: got first=%h second=%h expected 4000 a000", addr1, addr14);
      end
      checks++;
      if (done_at != 12 || ack_at != 25 || ack_cnt != 1) begin
         errors++;
         $display("FAIL prio_timing: got done=%0d ack=%0d acks=%0d expected 12 25 1", done_at, ack_at, ack_cnt);
      end
      checks++;
      if (crd !== 8'h83 || drd !== 8'h63) begin
         errors++;
         $display("FAIL prio_rdata: got cpu=%h dma=%h expected 83 63", crd, drd);
      end
   endtask

   task automatic test_overrun();
      int ack_at = -1, done_at = -1, done_cnt = 0;
      logic ovr4 = 1'b1, ovr6 = 1'b0, busy13 = 1'b0;
      logic [15:0] addr14 = 16'h0;
      logic [7:0] crd = 8'h00, drd = 8'h00;
      cb.dma_req = 1'b1;
      cb.dma_addr = 16'hA001;
      cb.dma_wr = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         if (k == 4) ovr4 = cb.cpu_overrun;
         if (k == 6) ovr6 = cb.cpu_overrun;
         if (k == 13) busy13 = cb.busy;
         if (k == 14) addr14 = cb.bus_addr;
         if (cb.dma_ack && ack_at < 0) begin
            ack_at = k;
            drd = cb.dma_rdata;
            cb.dma_req = 1'b0;
         end
         if (cb.cpu_done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               crd = cb.cpu_rdata;
            end
         end
         cb.cpu_req = (k == 3) || (k == 5);
         cb.cpu_addr = (k < 5) ? 16'h0150 : 16'h0200;
         cb.cpu_wr = 1'b0;
      end
      checks++;
      if (ack_at != 12 || drd !== 8'h62) begin
         errors++;
         $display("FAIL ovr_dma_ack: got at %0d rdata %h expected 12 62", ack_at, drd);
      end
      checks++;
      if (ovr4 !== 1'b0 || ovr6 !== 1'b1 || cb.cpu_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_flag: got %b%b%b expected 011", ovr4, ovr6, cb.cpu_overrun);
      end
      checks++;
      if (busy13 !== 1'b1 || addr14 !== 16'h0150) begin
         errors++;
         $display("FAIL ovr_pending_grant: got busy=%b addr=%h expected 1 0150", busy13, addr14);
      end
      checks++;
      if (done_at != 25 || done_cnt != 1 || crd !== 8'h92) begin
         errors++;
         $display("FAIL ovr_cpu_done: got at %0d count %0d rdata %h expected 25 1 92", done_at, done_cnt, crd);
      end
      checks++;
      if (cb.busy !== 1'b0 || cb.bus_addr !== 16'h0150) begin
         errors++;
         $display("FAIL ovr_second_dropped: got busy=%b addr=%h expected 0 0150", cb.busy, cb.bus_addr);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] strb5 = 2'b11;
      int events = 0, busy_cnt = 0;
      cb.cpu_req = 1'b1;
      cb.cpu_addr = 16'hA020;
      cb.cpu_wr = 1'b1;
      cb.cpu_wdata = 8'h99;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_sys);
         if (k == 5) begin
            strb5 = {cb.bus_nwr, cb.bus_ncs};
            reset = 1'b1;
         end
         cb.cpu_req = (k == 2);
         cb.cpu_addr = (k == 2) ? 16'h0300 : 16'hA020;
      end
      checks++;
      if (strb5 !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_strobing: got nwr,ncs=%b expected 00", strb5);
      end
      checks++;
      if ({cb.bus_nrd, cb.bus_nwr, cb.bus_ncs, cb.bus_dir, cb.bus_clk} !== 5'b11100) begin
         errors++;
         $display("FAIL rstmid_strobes: got %b expected 11100",
                  {cb.bus_nrd, cb.bus_nwr, cb.bus_ncs, cb.bus_dir, cb.bus_clk});
      end
      checks++;
      if ({cb.busy, cb.cpu_overrun, cb.bus_addr} !== {2'b00, 16'h0000}) begin
         errors++;
         $display("FAIL rstmid_cleared: got busy=%b ovr=%b addr=%h expected 0 0 0000",
                  cb.busy, cb.cpu_overrun, cb.bus_addr);
      end
      reset = 1'b0;
      for (int k = 7; k <= 36; k++) begin
         @(negedge clk_sys);
         if (cb.cpu_done || cb.dma_ack) events++;
         if (cb.busy || !cb.bus_nwr) busy_cnt++;
      end
      checks++;
      if (events != 0 || busy_cnt != 0) begin
         errors++;
         $display("FAIL rstmid_no_completion: got done/ack=%0d busy=%0d expected 0 0", events, busy_cnt);
      end
   endtask

   task automatic test_fast_back_to_back();
      int ack_cnt = 0, ack1 = -1, ack2 = -1, nrd_low = 0;
      logic [7:0] rd1 = 8'h00, rd2 = 8'h00;
      logic [15:0] addr5 = 16'h0;
      cf.dma_req = 1'b1;
      cf.dma_addr = 16'h1234;
      cf.dma_wr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_sys);
         if (k == 5) addr5 = cf.bus_addr;
         if (!cf.bus_nrd) nrd_low++;
         if (cf.dma_ack) begin
            ack_cnt++;
            if (ack_cnt == 1) begin
               ack1 = k;
               rd1 = cf.dma_rdata;
               cf.dma_addr = 16'h5678;
            end else if (ack_cnt == 2) begin
               ack2 = k;
               rd2 = cf.dma_rdata;
               cf.dma_req = 1'b0;
            end
         end
      end
      cf.dma_req = 1'b0;
      checks++;
      if (ack1 != 3 || ack2 != 7 || ack_cnt != 2) begin
         errors++;
         $display("FAIL fast_ack_timing: got %0d %0d count %0d expected 3 7 2", ack1, ack2, ack_cnt);
      end
      checks++;
      if (addr5 !== 16'h5678 || nrd_low != 2) begin
         errors++;
         $display("FAIL fast_b2b_grant: got addr=%h nrd_low=%0d expected 5678 2", addr5, nrd_low);
      end
      checks++;
      if (rd1 !== 8'hE5 || rd2 !== 8'hED) begin
         errors++;
         $display("FAIL fast_rdata: got %h %h expected e5 ed", rd1, rd2);
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      cb.cpu_req = 1'b0;  cb.cpu_addr = '0;  cb.cpu_wr = 1'b0;  cb.cpu_wdata = '0;
      cb.dma_req = 1'b0;  cb.dma_addr = '0;  cb.dma_wr = 1'b0;  cb.dma_wdata = '0;
      cf.cpu_req = 1'b0;  cf.cpu_addr = '0;  cf.cpu_wr = 1'b0;  cf.cpu_wdata = '0;
      cf.dma_req = 1'b0;  cf.dma_addr = '0;  cf.dma_wr = 1'b0;  cf.dma_wdata = '0;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_priority();
      test_overrun();
      test_reset_mid();
      test_fast_back_to_back();
      repeat (2) @(negedge clk_sys);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
